// File: rtl/mv_seq_controller.sv
// Command-driven sequencer for the systolic matrix-vector array: operand load,
// fetch/compute/drain stepping and valid/ready result readback.

module mv_seq_col_addr #(
    parameter int                   ADDR_SIZE = 10,
    parameter int                   COL       = 0,
    parameter logic [ADDR_SIZE-1:0] ZERO      = '1
) (
    input  logic                 col_en,
    input  logic [7:0]           cols,
    input  logic [ADDR_SIZE-1:0] row_base,
    output logic [ADDR_SIZE-1:0] addr
);
    // Columns beyond the active width read the zero point so idle PEs accumulate nothing.
    assign addr = (col_en && (32'(cols) > COL)) ? row_base + ADDR_SIZE'(COL) : ZERO;
endmodule

module mv_seq_controller #(
    parameter int                   WORD_SIZE       = 16,
    parameter int                   ADDR_SIZE       = 10,
    parameter int                   PE_NUMBER       = 64,
    parameter int                   MAX_ROWS        = 255,
    parameter int                   MEM_HEAD_ADDR   = 15,
    parameter logic [ADDR_SIZE-1:0] ZERO_POINT_ADDR = '1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [WORD_SIZE-1:0]           cmd_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [WORD_SIZE-1:0]           rsp_data,
    output logic                           array_clear,
    output logic                           array_read,
    output logic [PE_NUMBER*ADDR_SIZE-1:0] pe_t_addr,
    output logic [ADDR_SIZE-1:0]           l_d_addr,
    input  logic [WORD_SIZE-1:0]           l_d_o,
    output logic                           mem_w_en,
    output logic [ADDR_SIZE-1:0]           mem_w_addr,
    output logic [WORD_SIZE-1:0]           mem_w_data,
    output logic [ADDR_SIZE-1:0]           mem_r_addr,
    input  logic [WORD_SIZE-1:0]           mem_r_data,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_VEC, S_LOAD_MAT, S_FETCH, S_COMPUTE, S_DRAIN, S_READ_OUT
    } state_t;

    typedef enum logic [1:0] { RD_ADDR, RD_CAP, RD_HOLD } rd_ph_t;

    localparam logic [ADDR_SIZE-1:0] HEAD = ADDR_SIZE'(MEM_HEAD_ADDR);

    state_t                 state;
    rd_ph_t                 rd_ph;
    logic [7:0]             rows, cols;
    logic [15:0]            cnt, load_last;
    logic [ADDR_SIZE-1:0]   wr_addr, col_base;
    logic                   col_en, clr_q;

    logic [3:0]             opcode;
    logic [7:0]             arg;
    logic                   cmd_hs, dims_ok, start_acc;
    logic [15:0]            mat_words;
    logic [ADDR_SIZE-1:0]   mat_base, res_base;
    logic                   unused_cmd_bits;

    assign opcode          = cmd_data[15:12];
    assign arg             = cmd_data[7:0];
    assign unused_cmd_bits = ^cmd_data[11:8];
    assign cmd_hs          = cmd_valid && cmd_ready;
    assign dims_ok         = (rows != 8'd0) && (cols != 8'd0) &&
                             (32'(rows) <= MAX_ROWS) && (32'(cols) <= PE_NUMBER);
    assign mat_words       = 16'(rows) * 16'(cols);
    assign mat_base        = HEAD + ADDR_SIZE'(rows);
    assign res_base        = mat_base + ADDR_SIZE'(mat_words);
    assign start_acc       = (state == S_IDLE) && cmd_hs && (opcode == 4'h3) && dims_ok;

    assign busy        = (state != S_IDLE);
    assign cmd_ready   = (state == S_IDLE) || (state == S_LOAD_VEC) || (state == S_LOAD_MAT);
    assign array_read  = (state == S_DRAIN);
    // Held after reset until the first edge, then only during the START handshake.
    assign array_clear = clr_q | start_acc;

    // Operand writes are the accepted word itself; drain writes pass the array output through.
    always_comb begin
        mem_w_en   = 1'b0;
        mem_w_addr = ZERO_POINT_ADDR;
        mem_w_data = '0;
        if (state == S_LOAD_VEC || state == S_LOAD_MAT) begin
            mem_w_en   = cmd_valid;
            mem_w_addr = wr_addr;
            mem_w_data = cmd_data;
        end else if (state == S_DRAIN) begin
            mem_w_en   = 1'b1;
            mem_w_addr = wr_addr;
            mem_w_data = l_d_o;
        end
    end

    logic [PE_NUMBER-1:0][ADDR_SIZE-1:0] col_addr;

    genvar gi;
    generate
        for (gi = 0; gi < PE_NUMBER; gi++) begin : g_col
            mv_seq_col_addr #(
                .ADDR_SIZE (ADDR_SIZE),
                .COL       (gi),
                .ZERO      (ZERO_POINT_ADDR)
            ) u_col (
                .col_en   (col_en),
                .cols     (cols),
                .row_base (col_base),
                .addr     (col_addr[gi])
            );
        end
    endgenerate

    assign pe_t_addr = col_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            rd_ph      <= RD_ADDR;
            rows       <= '0;
            cols       <= '0;
            cnt        <= '0;
            load_last  <= '0;
            wr_addr    <= ZERO_POINT_ADDR;
            col_base   <= ZERO_POINT_ADDR;
            col_en     <= 1'b0;
            l_d_addr   <= ZERO_POINT_ADDR;
            mem_r_addr <= ZERO_POINT_ADDR;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            clr_q      <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: if (cmd_hs) begin
                    case (opcode)
                        4'h0: ;
                        4'h1: rows <= arg;
                        4'h2: cols <= arg;
                        4'h3: if (dims_ok) begin
                            state    <= S_FETCH;
                            cnt      <= '0;
                            l_d_addr <= HEAD;
                            col_base <= mat_base;
                            col_en   <= 1'b1;
                        end else err <= 1'b1;
                        4'h4: if (dims_ok) begin
                            state     <= S_LOAD_VEC;
                            cnt       <= '0;
                            load_last <= 16'(rows) - 16'd1;
                            wr_addr   <= HEAD;
                        end else err <= 1'b1;
                        4'h5: if (dims_ok) begin
                            state     <= S_LOAD_MAT;
                            cnt       <= '0;
                            load_last <= mat_words - 16'd1;
                            wr_addr   <= mat_base;
                        end else err <= 1'b1;
                        4'h6: if (dims_ok) begin
                            state      <= S_READ_OUT;
                            cnt        <= '0;
                            rd_ph      <= RD_ADDR;
                            mem_r_addr <= res_base;
                        end else err <= 1'b1;
                        default: err <= 1'b1;
                    endcase
                end
                S_LOAD_VEC, S_LOAD_MAT: if (cmd_valid) begin
                    wr_addr <= wr_addr + 1'b1;
                    cnt     <= cnt + 16'd1;
                    if (cnt == load_last) state <= S_IDLE;
                end
                S_FETCH: begin
                    if (cnt == 16'(rows) - 16'd1) begin
                        cnt      <= '0;
                        l_d_addr <= ZERO_POINT_ADDR;
                        col_en   <= 1'b0;
                        if (cols == 8'd1) begin
                            state   <= S_DRAIN;
                            wr_addr <= res_base;
                        end else begin
                            state <= S_COMPUTE;
                        end
                    end else begin
                        cnt      <= cnt + 16'd1;
                        l_d_addr <= l_d_addr + 1'b1;
                        col_base <= col_base + ADDR_SIZE'(cols);
                    end
                end
                // Lets the last fetched row ripple across the remaining cols-1 columns.
                S_COMPUTE: begin
                    if (cnt == 16'(cols) - 16'd2) begin
                        state   <= S_DRAIN;
                        cnt     <= '0;
                        wr_addr <= res_base;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DRAIN: begin
                    wr_addr <= wr_addr + 1'b1;
                    cnt     <= cnt + 16'd1;
                    if (cnt == 16'(cols) - 16'd1) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end
                end
                // The next address is presented while the current word waits in HOLD,
                // so a consumer that is always ready sees one word every two cycles.
                S_READ_OUT: begin
                    case (rd_ph)
                        RD_ADDR: rd_ph <= RD_CAP;
                        RD_CAP: begin
                            rsp_data   <= mem_r_data;
                            rsp_valid  <= 1'b1;
                            rd_ph      <= RD_HOLD;
                            mem_r_addr <= (cnt == 16'(cols) - 16'd1) ? ZERO_POINT_ADDR
                                                                     : mem_r_addr + 1'b1;
                        end
                        RD_HOLD: if (rsp_ready) begin
                            rsp_valid <= 1'b0;
                            if (cnt == 16'(cols) - 16'd1) begin
                                state <= S_IDLE;
                                cnt   <= '0;
                                rd_ph <= RD_ADDR;
                            end else begin
                                cnt   <= cnt + 16'd1;
                                rd_ph <= RD_CAP;
                            end
                        end
                        default: rd_ph <= RD_ADDR;
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
